// File: rtl/seq_divider_pkg.sv
// Shared constants for the sequential restoring divider.
// State encoding and the iteration-counter width helper.
package seq_divider_pkg;

    localparam logic [1:0] IDLE = 2'b00;
    localparam logic [1:0] ITER = 2'b01;
    localparam logic [1:0] FIX  = 2'b10;

    function automatic int cnt_width(input int w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step on {P, Q}.
// Emits the next partial remainder and the next quotient bits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_p,
    input  logic [WIDTH-1:0] i_q,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_p,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH:0] w_sh;
    logic [WIDTH:0] w_trial;

    // P < |B| holds on entry, so WIDTH+1 bits cover both trial signs.
    assign w_sh    = {i_p, i_q[WIDTH-1]};
    assign w_trial = w_sh - {1'b0, i_b};

    assign o_p = w_trial[WIDTH] ? w_sh[WIDTH-1:0]
                                : w_trial[WIDTH-1:0];
    assign o_q = {i_q[WIDTH-2:0], ~w_trial[WIDTH]};

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned divider, z_result = {remainder, quotient}.
// SEQ_DIVIDER_ZERO_FAST_EN: zero divisor skips straight to FIX.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = cnt_width(WIDTH)
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic [2*WIDTH-1:0] z_result,
    output logic               div_zero
);

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_p;
    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_a;
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_bz;
    logic             r_busy;
    logic             r_done;
    logic             r_dz;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_rem;

    logic             w_neg_a;
    logic             w_neg_b;
    logic             w_bz;
    logic [WIDTH-1:0] w_abs_a;
    logic [WIDTH-1:0] w_abs_b;
    logic [WIDTH-1:0] w_p;
    logic [WIDTH-1:0] w_q;

    assign w_neg_a = signed_mode & dividend[WIDTH-1];
    assign w_neg_b = signed_mode & divisor[WIDTH-1];
    assign w_bz    = (divisor == '0);
    assign w_abs_a = w_neg_a ? -dividend : dividend;
    assign w_abs_b = w_neg_b ? -divisor : divisor;

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_p (r_p),
        .i_q (r_q),
        .i_b (r_b),
        .o_p (w_p),
        .o_q (w_q)
    );

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_p      <= '0;
            r_q      <= '0;
            r_b      <= '0;
            r_a      <= '0;
            r_sign_q <= 1'b0;
            r_sign_r <= 1'b0;
            r_bz     <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dz     <= 1'b0;
            r_quot   <= '0;
            r_rem    <= '0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (start) begin
                        r_p      <= '0;
                        r_q      <= w_abs_a;
                        r_b      <= w_abs_b;
                        r_a      <= dividend;
                        r_cnt    <= '0;
                        r_sign_q <= w_neg_a ^ w_neg_b;
                        r_sign_r <= w_neg_a;
                        r_bz     <= w_bz;
                        r_busy   <= 1'b1;
                        r_dz     <= 1'b0;
`ifdef SEQ_DIVIDER_ZERO_FAST_EN
                        r_state  <= w_bz ? FIX : ITER;
`else
                        r_state  <= ITER;
`endif
                    end
                end
                ITER: begin
                    r_p   <= w_p;
                    r_q   <= w_q;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CNT_W'(WIDTH - 1))
                        r_state <= FIX;
                end
                FIX: begin
                    // Truncating division: remainder follows the dividend.
                    if (r_bz) begin
                        r_quot <= '1;
                        r_rem  <= r_a;
                        r_dz   <= 1'b1;
                    end else begin
                        r_quot <= r_sign_q ? -r_q : r_q;
                        r_rem  <= r_sign_r ? -r_p : r_p;
                    end
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign quotient  = r_quot;
    assign remainder = r_rem;
    assign z_result  = {r_rem, r_quot};
    assign div_zero  = r_dz;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider at WIDTH=32.
// Honours SEQ_DIVIDER_ZERO_FAST_EN for zero-divisor latency.
module tb_seq_divider;

    localparam int W = 32;

    logic         clk;
    logic         clr;
    logic         start;
    logic         signed_mode;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic [2*W-1:0] z_result;
    logic         div_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dz;
        int           due;
    } exp_t;

    exp_t exp_q[$];
    int   total;
    int   bad;
    int   cyc;

    seq_divider #(.WIDTH(W)) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .signed_mode (signed_mode),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .z_result    (z_result),
        .div_zero    (div_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%h want=%h", nm, act, want);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (done) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("quotient", 64'(quotient), 64'(e.q));
                chk("remainder", 64'(remainder), 64'(e.r));
                chk("z_result", z_result, {e.r, e.q});
                chk("div_zero", 64'(div_zero), 64'(e.dz));
                chk("busy_at_done", 64'(busy), 64'd0);
                chk("latency", 64'(cyc), 64'(e.due));
            end
        end
    end

    task automatic push_exp(input logic [W-1:0] b,
                            input logic [W-1:0] eq,
                            input logic [W-1:0] er,
                            input logic edz);
        exp_t e;
        e.q  = eq;
        e.r  = er;
        e.dz = edz;
`ifdef SEQ_DIVIDER_ZERO_FAST_EN
        e.due = (b == '0) ? cyc + 2 : cyc + W + 2;
`else
        e.due = cyc + W + 2;
`endif
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [W-1:0] a,
                         input logic [W-1:0] b,
                         input logic sm);
        start       = 1'b1;
        dividend    = a;
        divisor     = b;
        signed_mode = sm;
    endtask

    task automatic launch(input logic [W-1:0] a,
                          input logic [W-1:0] b,
                          input logic sm,
                          input logic [W-1:0] eq,
                          input logic [W-1:0] er,
                          input logic edz);
        @(negedge clk);
        drive(a, b, sm);
        push_exp(b, eq, er, edz);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) chk("done_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        exp_t junk;
        total       = 0;
        bad         = 0;
        clr         = 1'b0;
        start       = 1'b0;
        signed_mode = 1'b0;
        dividend    = '0;
        divisor     = '0;

        #12;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_z", z_result, 64'd0);
        chk("rst_dz", 64'(div_zero), 64'd0);
        @(negedge clk);
        clr = 1'b1;

        launch(32'h0000000F, 32'h00000004, 1'b0,
               32'h00000003, 32'h00000003, 1'b0);
        wait_done();

        launch(32'hFFFFFFF9, 32'h00000002, 1'b1,
               32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
        wait_done();

        launch(32'h00000007, 32'hFFFFFFFE, 1'b1,
               32'hFFFFFFFD, 32'h00000001, 1'b0);
        wait_done();

        launch(32'h80000000, 32'hFFFFFFFF, 1'b1,
               32'h80000000, 32'h00000000, 1'b0);
        wait_done();

        launch(32'hFFFFFFFF, 32'h00000010, 1'b0,
               32'h0FFFFFFF, 32'h0000000F, 1'b0);
        wait_done();

        launch(32'hFFFFFFFF, 32'h00000010, 1'b1,
               32'h00000000, 32'hFFFFFFFF, 1'b0);
        wait_done();

        launch(32'h00000012, 32'h00000000, 1'b0,
               32'hFFFFFFFF, 32'h00000012, 1'b1);
        wait_done();
        repeat (3) @(negedge clk);
        chk("dz_hold", 64'(div_zero), 64'd1);
        chk("q_hold", 64'(quotient), 64'hFFFFFFFF);

        launch(32'hFFFFFFEE, 32'h00000000, 1'b1,
               32'hFFFFFFFF, 32'hFFFFFFEE, 1'b1);
        wait_done();

        launch(32'h0000000F, 32'h00000004, 1'b0,
               32'h00000003, 32'h00000003, 1'b0);
        chk("dz_cleared", 64'(div_zero), 64'd0);
        chk("busy_run", 64'(busy), 64'd1);
        repeat (5) @(negedge clk);
        drive(32'h00000009, 32'h00000003, 1'b1);
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        drive(32'h00000064, 32'h00000007, 1'b0);
        @(negedge clk);
        start = 1'b0;
        wait_done();
        repeat (2) @(negedge clk);

        @(negedge clk);
        drive(32'h000000C8, 32'h0000000A, 1'b0);
        push_exp(32'h0000000A, 32'h00000014, 32'h00000000, 1'b0);
        wait_done();
        drive(32'h00000032, 32'h00000007, 1'b0);
        push_exp(32'h00000007, 32'h00000007, 32'h00000001, 1'b0);
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy", 64'(busy), 64'd1);
        wait_done();

        launch(32'h000003E8, 32'h00000003, 1'b0,
               32'h0000014D, 32'h00000001, 1'b0);
        repeat (9) @(negedge clk);
        clr = 1'b0;
        junk = exp_q.pop_back();
        #1;
        chk("clr_busy", 64'(busy), 64'd0);
        chk("clr_done", 64'(done), 64'd0);
        chk("clr_q", 64'(quotient), 64'd0);
        chk("clr_r", 64'(remainder), 64'd0);
        repeat (2) @(negedge clk);
        clr = 1'b1;

        launch(32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 1'b0);
        wait_done();

        repeat (40) @(negedge clk);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
